// File: rtl/seg_pkg.sv
// Shared types and constants for the segment-display arbiter.
// Holds the FSM encoding, blanking constants and small bit-manipulation helpers.
package seg_pkg;

    localparam int          NREQ         = 4;
    localparam logic [3:0]  BLANK_NIBBLE = 4'hF;
    localparam logic [31:0] BLANK_WORD   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        OPEN = 2'd2
    } state_t;

    // Isolate the lowest set bit: bit 0 is the highest-priority requester.
    function automatic logic [NREQ-1:0] lowest_onehot(input logic [NREQ-1:0] v);
        return v & (~v + NREQ'(1));
    endfunction

    function automatic logic [31:0] blank_digits(input logic [31:0] word,
                                                 input logic [7:0]  mask);
        logic [31:0] res;
        res = word;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                res[4*i +: 4] = BLANK_NIBBLE;
            end else begin
                res[4*i +: 4] = word[4*i +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_blink_gen.sv
// Blink phase generator: counts 1 kHz ticks modulo BLINK_HALF_MS and toggles the phase at each wrap.
// A restart pulse (ownership change) clears both counter and phase.
module seg_blink_gen
    import seg_pkg::*;
#(
    parameter int BLINK_HALF_MS = 250
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_pls_1k,
    input  logic i_restart,
    output logic o_phase
);

    localparam logic [15:0] LAST = 16'(BLINK_HALF_MS - 1);

    logic [15:0] cnt_r;
    logic        phase_r;

    // Half-period counter and phase flop; restart beats a coincident tick.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            cnt_r   <= 16'd0;
            phase_r <= 1'b0;
        end else if (i_restart) begin
            cnt_r   <= 16'd0;
            phase_r <= 1'b0;
        end else if (i_pls_1k) begin
            if (cnt_r == LAST) begin
                cnt_r   <= 16'd0;
                phase_r <= ~phase_r;
            end else begin
                cnt_r   <= cnt_r + 16'd1;
            end
        end
    end

    assign o_phase = phase_r;

endmodule

// File: rtl/seg_disp_arb.sv
// Four-requester arbiter for one 8-digit BCD display with a minimum ownership time.
// Optional digit blinking is enabled by defining SEG_DISP_ARB_BLINK_EN.
module seg_disp_arb
    import seg_pkg::*;
#(
    parameter int HOLD_MS       = 500,
    parameter int BLINK_HALF_MS = 250
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_pls_1k,
    input  logic [3:0]    i_req,
    input  logic [127:0]  i_bcd_flat,
    input  logic [7:0]    i_blink_mask,
    output logic [31:0]   o_bcd8d,
    output logic [3:0]    o_grant,
    output logic          o_busy
);

    localparam logic [9:0] HOLD_LOAD = 10'(HOLD_MS - 1);

    state_t      state_r, state_nxt;
    logic [3:0]  grant_r, grant_nxt;
    logic [9:0]  hold_r, hold_nxt;
    logic        busy_r;
    logic [31:0] bcd_r;
    logic [31:0] slice_s;
    logic [31:0] disp_s;
    logic        owner_live_s;
    logic [3:0]  higher_s;

    assign owner_live_s = |(i_req & grant_r);
    // For a one-hot owner, grant-1 is the mask of every higher-priority index.
    assign higher_s     = i_req & (grant_r - 4'd1);

    // Next-state, grant and hold-counter decisions; owner release wins over a tick.
    always_comb begin
        state_nxt = state_r;
        grant_nxt = grant_r;
        hold_nxt  = hold_r;
        case (state_r)
            IDLE: begin
                if (|i_req) begin
                    grant_nxt = lowest_onehot(i_req);
                    hold_nxt  = HOLD_LOAD;
                    state_nxt = HOLD;
                end else begin
                    grant_nxt = 4'd0;
                    hold_nxt  = 10'd0;
                end
            end
            HOLD, OPEN: begin
                if (!owner_live_s) begin
                    if (|i_req) begin
                        grant_nxt = lowest_onehot(i_req);
                        hold_nxt  = HOLD_LOAD;
                        state_nxt = HOLD;
                    end else begin
                        grant_nxt = 4'd0;
                        hold_nxt  = 10'd0;
                        state_nxt = IDLE;
                    end
                end else if (state_r == OPEN) begin
                    if (|higher_s) begin
                        grant_nxt = lowest_onehot(higher_s);
                        hold_nxt  = HOLD_LOAD;
                        state_nxt = HOLD;
                    end else begin
                        hold_nxt  = hold_r;
                    end
                end else if (i_pls_1k) begin
                    if (hold_r == 10'd0) begin
                        state_nxt = OPEN;
                    end else begin
                        hold_nxt  = hold_r - 10'd1;
                    end
                end else begin
                    hold_nxt = hold_r;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 4'd0;
                hold_nxt  = 10'd0;
            end
        endcase
    end

    // Select the current owner's data word, blank when nobody owns the display.
    always_comb begin
        case (grant_r)
            4'b0001: slice_s = i_bcd_flat[31:0];
            4'b0010: slice_s = i_bcd_flat[63:32];
            4'b0100: slice_s = i_bcd_flat[95:64];
            4'b1000: slice_s = i_bcd_flat[127:96];
            default: slice_s = BLANK_WORD;
        endcase
    end

`ifdef SEG_DISP_ARB_BLINK_EN
    logic phase_s;
    logic restart_s;

    assign restart_s = (grant_nxt != grant_r);

    seg_blink_gen #(
        .BLINK_HALF_MS (BLINK_HALF_MS)
    ) u_blink (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_pls_1k  (i_pls_1k),
        .i_restart (restart_s),
        .o_phase   (phase_s)
    );

    assign disp_s = phase_s ? blank_digits(slice_s, i_blink_mask) : slice_s;
`else
    logic unused_blink_s;

    assign unused_blink_s = ^{i_blink_mask, 16'(BLINK_HALF_MS)};
    assign disp_s         = slice_s;
`endif

    // State, grant, busy and display registers.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_r <= IDLE;
            grant_r <= 4'd0;
            hold_r  <= 10'd0;
            busy_r  <= 1'b0;
            bcd_r   <= BLANK_WORD;
        end else begin
            state_r <= state_nxt;
            grant_r <= grant_nxt;
            hold_r  <= hold_nxt;
            busy_r  <= |grant_nxt;
            bcd_r   <= disp_s;
        end
    end

    assign o_grant = grant_r;
    assign o_busy  = busy_r;
    assign o_bcd8d = bcd_r;

endmodule

// File: tb/tb_seg_disp_arb.sv
// Self-checking bench for seg_disp_arb: directed table, hand sequences and a
// randomized run against an ownership-level reference model.
module tb_seg_disp_arb;

    localparam int HOLD_MS = 4;
    localparam int HALF    = 2;
`ifdef SEG_DISP_ARB_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn;
    logic         pls;
    logic [3:0]   req;
    logic [127:0] flat;
    logic [7:0]   mask;
    logic [31:0]  bcd;
    logic [3:0]   grant;
    logic         busy;

    always #5 clk = ~clk;

    seg_disp_arb #(
        .HOLD_MS       (HOLD_MS),
        .BLINK_HALF_MS (HALF)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_pls_1k     (pls),
        .i_req        (req),
        .i_bcd_flat   (flat),
        .i_blink_mask (mask),
        .o_bcd8d      (bcd),
        .o_grant      (grant),
        .o_busy       (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: owner index, pulses seen since the grant, pulses since last grant change.
    int m_owner  = -1;
    int m_pulses = 0;
    int m_k      = 0;
    logic [31:0] slices [4];

    typedef struct {
        logic        rstn;
        logic [3:0]  req;
        logic        pls;
        logic [3:0]  g;
        logic [31:0] b;
    } vec_t;

    vec_t tab [17];

    function automatic int lowest_idx(input logic [3:0] r);
        for (int i = 0; i < 4; i++) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] q, input logic p,
                        input bit use_tab, input logic [3:0] tg, input logic [31:0] tb,
                        input string name);
        logic [3:0]  eg;
        logic [31:0] eb;
        int          nown;
        int          lo;
        rstn = r;
        req  = q;
        pls  = p;
        flat = {slices[3], slices[2], slices[1], slices[0]};
        if (!r) begin
            eb       = 32'hFFFF_FFFF;
            nown     = -1;
            m_pulses = 0;
            m_k      = 0;
        end else begin
            if (m_owner < 0) begin
                eb = 32'hFFFF_FFFF;
            end else begin
                eb = slices[m_owner];
                if (BLINK && ((m_k / HALF) % 2 == 1)) begin
                    for (int i = 0; i < 8; i++) begin
                        if (mask[i]) eb[4*i +: 4] = 4'hF;
                    end
                end
            end
            lo   = lowest_idx(q);
            nown = m_owner;
            if (m_owner < 0 || !q[m_owner]) begin
                nown = lo;
            end else if (m_pulses >= HOLD_MS && lo < m_owner) begin
                nown = lo;
            end
            if (nown != m_owner) begin
                m_pulses = 0;
                m_k      = 0;
            end else if (p) begin
                m_pulses++;
                m_k++;
            end
        end
        m_owner = nown;
        eg = (m_owner < 0) ? 4'd0 : 4'(1 << m_owner);
        if (use_tab) begin
            eg = tg;
            eb = tb;
        end
        @(posedge clk);
        #1;
        vectors++;
        check({name, "/grant"}, {28'd0, grant}, {28'd0, eg});
        check({name, "/busy"},  {31'd0, busy},  {31'd0, |eg});
        check({name, "/bcd"},   bcd, eb);
    endtask

    initial begin
        slices[0] = 32'h1234_5678;
        slices[1] = 32'h2345_6781;
        slices[2] = 32'h3456_7812;
        slices[3] = 32'h4567_8123;
        mask = 8'h00;

        tab[0]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 32'hFFFF_FFFF};
        tab[1]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 32'hFFFF_FFFF};
        tab[2]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 32'h3456_7812};
        tab[3]  = '{1'b1, 4'b0100, 1'b1, 4'b0100, 32'h3456_7812};
        tab[4]  = '{1'b1, 4'b0101, 1'b0, 4'b0100, 32'h3456_7812};
        tab[5]  = '{1'b1, 4'b0101, 1'b1, 4'b0100, 32'h3456_7812};
        tab[6]  = '{1'b1, 4'b0101, 1'b1, 4'b0100, 32'h3456_7812};
        tab[7]  = '{1'b1, 4'b0101, 1'b0, 4'b0100, 32'h3456_7812};
        tab[8]  = '{1'b1, 4'b0101, 1'b1, 4'b0100, 32'h3456_7812};
        tab[9]  = '{1'b1, 4'b0101, 1'b0, 4'b0001, 32'h3456_7812};
        tab[10] = '{1'b1, 4'b0101, 1'b0, 4'b0001, 32'h1234_5678};
        tab[11] = '{1'b1, 4'b0110, 1'b0, 4'b0010, 32'h1234_5678};
        tab[12] = '{1'b1, 4'b0110, 1'b0, 4'b0010, 32'h2345_6781};
        tab[13] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 32'h2345_6781};
        tab[14] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 32'h3456_7812};
        tab[15] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 32'h3456_7812};
        tab[16] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 32'hFFFF_FFFF};

        for (int i = 0; i < 17; i++) begin
            step(tab[i].rstn, tab[i].req, tab[i].pls, 1'b1, tab[i].g, tab[i].b,
                 $sformatf("tab%0d", i));
        end

        // Reset pulse mid-OPEN with the request held, then regrant.
        step(1'b1, 4'b1000, 1'b0, 1'b1, 4'b1000, 32'hFFFF_FFFF, "open_grant");
        for (int i = 0; i < 4; i++) step(1'b1, 4'b1000, 1'b1, 1'b0, 4'd0, 32'd0, "open_pls");
        step(1'b1, 4'b1000, 1'b0, 1'b1, 4'b1000, 32'h4567_8123, "open_held");
        step(1'b0, 4'b1000, 1'b0, 1'b1, 4'b0000, 32'hFFFF_FFFF, "mid_rst");
        step(1'b1, 4'b1000, 1'b0, 1'b1, 4'b1000, 32'hFFFF_FFFF, "rst_regrant");
        step(1'b1, 4'b1000, 1'b0, 1'b1, 4'b1000, 32'h4567_8123, "rst_data");

        // Blink pattern on requester 0.
        slices[0] = 32'h1234_5678;
        mask      = 8'h81;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 4'b0001, 1'(i % 2), 1'b0, 4'd0, 32'd0, "blink");
        end

        // Randomized run against the model.
        req = 4'b0000;
        for (int i = 0; i < 800; i++) begin
            logic [3:0] q;
            q = req;
            if ($urandom_range(0, 7) == 0) q = 4'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                slices[$urandom_range(0, 3)] = $urandom;
                mask = 8'($urandom);
            end
            step(1'($urandom_range(0, 63) != 0), q, 1'($urandom_range(0, 2) == 0),
                 1'b0, 4'd0, 32'd0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
